branch_predictor: RTL and testbench

Dynamic branch predictor for the five-stage RV32IM pipeline. Sits beside the IF stage and predicts direction and target for the current fetch PC from a direct-mapped table of 2-bit saturating counters with tags and targets. Trains from branch outcomes resolved in EX by the branch comparator, and flags mispredictions with a redirect PC. Keeps branch and mispredict counters for performance evaluation.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side training bundle for the branch predictor.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken,
    output upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict,
    input  redirect_pc, branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken,
    input  upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict,
    output redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter predictor with tagged targets.
// Lookup is combinational; training happens on the EX resolve edge.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int N  = 1 << IDX_BITS;
  localparam int TW = 30 - IDX_BITS;

  logic          valid_q [N];
  logic [TW-1:0] tag_q   [N];
  logic [1:0]    ctr_q   [N];
  logic [31:0]   tgt_q   [N];
  logic [31:0]   bcnt_q, bcnt_d;
  logic [31:0]   mcnt_q, mcnt_d;

  logic [IDX_BITS-1:0] lidx, uidx;
  logic [TW-1:0]       ltag, utag;
  logic                lhit, uhit;
  logic [31:0]         correct_pc;
  logic                mispred;

  logic        wr_en;
  logic [1:0]  ctr_d;
  logic [31:0] tgt_d;

  logic unused_pred_taken;
  assign unused_pred_taken = bp.upd_pred_taken;

  assign lidx = bp.if_pc[IDX_BITS+1:2];
  assign ltag = bp.if_pc[31:IDX_BITS+2];
  assign uidx = bp.upd_pc[IDX_BITS+1:2];
  assign utag = bp.upd_pc[31:IDX_BITS+2];

  assign lhit = valid_q[lidx] && (tag_q[lidx] == ltag);
  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

  assign bp.pred_taken  = lhit && ctr_q[lidx][1];
  assign bp.pred_target = bp.pred_taken ? tgt_q[lidx]
                                        : bp.if_pc + 32'd4;

  assign correct_pc = (bp.upd_valid && bp.upd_taken) ? bp.upd_target
                                                     : bp.upd_pc + 32'd4;
  assign mispred    = bp.upd_valid &&
                      (correct_pc != bp.upd_pred_target);

  assign bp.mispredict       = mispred;
  assign bp.redirect_pc      = correct_pc;
  assign bp.branch_count     = bcnt_q;
  assign bp.mispredict_count = mcnt_q;

  // Hits train the counter; only a taken miss allocates.
  always_comb begin
    wr_en = 1'b0;
    ctr_d = 2'b10;
    tgt_d = bp.upd_target;
    if (bp.upd_valid) begin
      if (uhit) begin
        wr_en = 1'b1;
        if (bp.upd_taken) begin
          ctr_d = (ctr_q[uidx] == 2'b11) ? 2'b11 : ctr_q[uidx] + 2'd1;
        end else begin
          ctr_d = (ctr_q[uidx] == 2'b00) ? 2'b00 : ctr_q[uidx] - 2'd1;
          tgt_d = tgt_q[uidx];
        end
      end else if (bp.upd_taken) begin
        wr_en = 1'b1;
      end
    end
  end

  assign bcnt_d = bcnt_q + {31'd0, bp.upd_valid};
  assign mcnt_d = mcnt_q + {31'd0, mispred};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        ctr_q[uidx]   <= ctr_d;
        tgt_q[uidx]   <= tgt_d;
      end
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor.
// Each row drives one cycle and checks outputs before that cycle's edge.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n;

  branch_predictor_if bp ();

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] uptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mp;
    logic [31:0] e_rd;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  string tag;

  vec_t vecs[24];

  function automatic vec_t v(
    input logic r, input logic [31:0] pc,
    input logic uv, input logic [31:0] upc,
    input logic ut, input logic [31:0] utgt,
    input logic [31:0] uptgt,
    input logic ept, input logic [31:0] eptgt,
    input logic emp, input logic [31:0] erd,
    input logic [31:0] ebc, input logic [31:0] emc);
    vec_t x;
    x.rst = r; x.pc = pc; x.uv = uv; x.upc = upc;
    x.ut = ut; x.utgt = utgt; x.uptgt = uptgt;
    x.e_pt = ept; x.e_ptgt = eptgt; x.e_mp = emp;
    x.e_rd = erd; x.e_bc = ebc; x.e_mc = emc;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt,
                       input logic [31:0] uptgt);
    rst_n              = r;
    bp.if_pc           = pc;
    bp.upd_valid       = uv;
    bp.upd_pc          = upc;
    bp.upd_taken       = ut;
    bp.upd_target      = utgt;
    bp.upd_pred_target = uptgt;
    bp.upd_pred_taken  = (uptgt != upc + 32'd4);
  endtask

  task automatic chk_all(input logic ept, input logic [31:0] eptgt,
                         input logic emp, input logic [31:0] erd,
                         input logic [31:0] ebc, input logic [31:0] emc);
    chk("pred_taken", {31'd0, bp.pred_taken}, {31'd0, ept});
    chk("pred_target", bp.pred_target, eptgt);
    chk("mispredict", {31'd0, bp.mispredict}, {31'd0, emp});
    if (bp.upd_valid) chk("redirect_pc", bp.redirect_pc, erd);
    chk("branch_count", bp.branch_count, ebc);
    chk("mispredict_count", bp.mispredict_count, emc);
  endtask

  initial begin
    vecs[0]  = v(1'b1,'h100,1'b0,'h000,1'b0,'h000,'h000, 1'b0,'h104,1'b0,'h004, 0,0);
    vecs[1]  = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h104, 1'b0,'h104,1'b1,'h080, 0,0);
    vecs[2]  = v(1'b1,'h100,1'b0,'h100,1'b0,'h000,'h000, 1'b1,'h080,1'b0,'h104, 1,1);
    vecs[3]  = v(1'b1,'h100,1'b1,'h100,1'b0,'h080,'h080, 1'b1,'h080,1'b1,'h104, 1,1);
    vecs[4]  = v(1'b1,'h100,1'b0,'h100,1'b0,'h000,'h000, 1'b0,'h104,1'b0,'h104, 2,2);
    vecs[5]  = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h104, 1'b0,'h104,1'b1,'h080, 2,2);
    vecs[6]  = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h080, 1'b1,'h080,1'b0,'h080, 3,3);
    vecs[7]  = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h080, 1'b1,'h080,1'b0,'h080, 4,3);
    vecs[8]  = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h080, 1'b1,'h080,1'b0,'h080, 5,3);
    vecs[9]  = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h080, 1'b1,'h080,1'b0,'h080, 6,3);
    vecs[10] = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h080, 1'b1,'h080,1'b0,'h080, 7,3);
    vecs[11] = v(1'b1,'h100,1'b1,'h100,1'b0,'h080,'h080, 1'b1,'h080,1'b1,'h104, 8,3);
    vecs[12] = v(1'b1,'h100,1'b0,'h100,1'b0,'h000,'h000, 1'b1,'h080,1'b0,'h104, 9,4);
    vecs[13] = v(1'b1,'h100,1'b1,'h100,1'b1,'h080,'h080, 1'b1,'h080,1'b0,'h080, 9,4);
    vecs[14] = v(1'b1,'h100,1'b1,'h100,1'b1,'h200,'h080, 1'b1,'h080,1'b1,'h200, 10,4);
    vecs[15] = v(1'b1,'h100,1'b0,'h100,1'b0,'h000,'h000, 1'b1,'h200,1'b0,'h104, 11,5);
    vecs[16] = v(1'b1,'h140,1'b1,'h140,1'b1,'h300,'h144, 1'b0,'h144,1'b1,'h300, 11,5);
    vecs[17] = v(1'b1,'h100,1'b0,'h100,1'b0,'h000,'h000, 1'b0,'h104,1'b0,'h104, 12,6);
    vecs[18] = v(1'b1,'h140,1'b1,'h180,1'b0,'h400,'h184, 1'b1,'h300,1'b0,'h184, 12,6);
    vecs[19] = v(1'b1,'h142,1'b0,'h140,1'b0,'h000,'h000, 1'b1,'h300,1'b0,'h144, 13,6);
    vecs[20] = v(1'b0,'h140,1'b1,'h140,1'b1,'h500,'h300, 1'b1,'h300,1'b1,'h500, 13,6);
    vecs[21] = v(1'b1,'h140,1'b0,'h140,1'b0,'h000,'h000, 1'b0,'h144,1'b0,'h144, 0,0);
    vecs[22] = v(1'b1,'h100,1'b1,'h140,1'b0,'h020,'h144, 1'b0,'h104,1'b0,'h144, 0,0);
    vecs[23] = v(1'b1,'h140,1'b0,'h140,1'b0,'h000,'h000, 1'b0,'h144,1'b0,'h144, 1,0);

    // Reset with garbage update inputs held active.
    drive(1'b0, 'h100, 1'b1, 'h100, 1'b1, 'h999, 'h104);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b1, 'h100, 1'b0, 'h000, 1'b0, 'h000, 'h000);
    #2;
    tag = "reset";
    chk_all(1'b0, 'h104, 1'b0, 'h004, 0, 0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].pc, vecs[i].uv, vecs[i].upc,
            vecs[i].ut, vecs[i].utgt, vecs[i].uptgt);
      #2;
      tag = $sformatf("row%0d", i);
      chk_all(vecs[i].e_pt, vecs[i].e_ptgt, vecs[i].e_mp,
              vecs[i].e_rd, vecs[i].e_bc, vecs[i].e_mc);
    end

    // Top-of-memory PC: fall-through wraps to zero, index 15 allocates.
    @(negedge clk);
    drive(1'b1, 'hFFFF_FFFC, 1'b1, 'hFFFF_FFFC, 1'b1, 'h010, 'h000);
    #2;
    tag = "wrap_upd";
    chk_all(1'b0, 'h000, 1'b1, 'h010, 1, 0);

    @(negedge clk);
    drive(1'b1, 'hFFFF_FFFC, 1'b0, 'h000, 1'b0, 'h000, 'h000);
    #2;
    tag = "wrap_hit";
    chk_all(1'b1, 'h010, 1'b0, 'h004, 2, 1);

    // Same index 15, tag 0: must miss.
    bp.if_pc = 'h03C;
    #1;
    tag = "wrap_alias";
    chk("pred_taken", {31'd0, bp.pred_taken}, 32'd0);
    chk("pred_target", bp.pred_target, 'h040);

    // Idle cycle with update fields set but valid low changes nothing.
    @(negedge clk);
    drive(1'b1, 'hFFFF_FFFC, 1'b0, 'hFFFF_FFFC, 1'b0, 'h000, 'h123);
    @(negedge clk);
    #2;
    tag = "idle";
    chk_all(1'b1, 'h010, 1'b0, 'h000, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
